// File: rtl/reaction_session_ctrl.sv
// Reaction-timer session sequencer: 1 ms timebase, pseudo-random prep delay,
// BCD reaction measurement, false-start/timeout handling and best-time tracking.
module reaction_session_ctrl #(
  parameter int unsigned TICK_DIV    = 100000,
  parameter int unsigned NUM_TRIALS  = 5,
  parameter int unsigned PREP_MIN_MS = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_btn,
  input  logic        resp_btn,
  output logic        stim_led,
  output logic        busy,
  output logic [2:0]  state,
  output logic [2:0]  trial_idx,
  output logic [15:0] result_bcd,
  output logic [15:0] best_bcd,
  output logic        result_valid,
  output logic        false_start,
  output logic        session_done
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_PREP   = 3'd1,
    S_STIM   = 3'd2,
    S_RESULT = 3'd3,
    S_FAULT  = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  localparam int unsigned   TW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [15:0]   BCD_MAX   = 16'h9999;

  state_t        r_state;
  logic [2:0]    r_flags;  // {busy, stim_led, session_done}, registered with the state
  logic [2:0]    r_trial;
  logic [15:0]   r_lfsr;
  logic [15:0]   r_prep_ms;
  logic [15:0]   r_bcd;
  logic [15:0]   r_result;
  logic [15:0]   r_best;
  logic [TW-1:0] r_tick_cnt;
  logic          r_start_q;
  logic          r_resp_q;
  logic          r_result_valid;
  logic          r_false_start;

  logic          w_tick;
  logic          w_start_rise;
  logic          w_resp_rise;
  logic [15:0]   w_prep_load;
  logic [15:0]   w_bcd_inc;

  function automatic logic [2:0] flags_of(input state_t s);
    return {(s == S_PREP) || (s == S_STIM) || (s == S_RESULT) || (s == S_FAULT),
            (s == S_STIM), (s == S_DONE)};
  endfunction

  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        c;
    r = v;
    c = 1'b1;
    for (int unsigned d = 0; d < 4; d++) begin
      if (c) begin
        if (v[4*d +: 4] == 4'd9) begin
          r[4*d +: 4] = 4'd0;
        end else begin
          r[4*d +: 4] = v[4*d +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  assign w_tick       = (r_tick_cnt == TICK_LAST);
  assign w_start_rise = start_btn & ~r_start_q;
  assign w_resp_rise  = resp_btn & ~r_resp_q;
  assign w_prep_load  = 16'(PREP_MIN_MS) + {5'd0, r_lfsr[10:0]};
  assign w_bcd_inc    = bcd_inc(r_bcd);

  // Galois LFSR, taps 0xB400, plus the button edge-detect stage
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_lfsr    <= 16'hACE1;
      r_start_q <= 1'b0;
      r_resp_q  <= 1'b0;
    end else begin
      r_lfsr    <= {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);
      r_start_q <= start_btn;
      r_resp_q  <= resp_btn;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state        <= S_IDLE;
      r_flags        <= '0;
      r_trial        <= '0;
      r_prep_ms      <= '0;
      r_bcd          <= '0;
      r_result       <= '0;
      r_best         <= BCD_MAX;
      r_tick_cnt     <= '0;
      r_result_valid <= 1'b0;
      r_false_start  <= 1'b0;
    end else begin
      r_result_valid <= 1'b0;
      r_false_start  <= 1'b0;
      r_tick_cnt     <= w_tick ? '0 : r_tick_cnt + TW'(1);
      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_start_rise) begin
            r_trial    <= '0;
            r_best     <= BCD_MAX;
            r_prep_ms  <= w_prep_load;
            r_tick_cnt <= '0;
            r_state    <= S_PREP;
            r_flags    <= flags_of(S_PREP);
          end
        end
        S_PREP: begin
          if (w_resp_rise) begin
            r_false_start <= 1'b1;
            r_state       <= S_FAULT;
            r_flags       <= flags_of(S_FAULT);
          end else if (w_tick) begin
            if (r_prep_ms == 16'd1) begin
              r_bcd      <= '0;
              r_tick_cnt <= '0;
              r_state    <= S_STIM;
              r_flags    <= flags_of(S_STIM);
            end else begin
              r_prep_ms <= r_prep_ms - 16'd1;
            end
          end
        end
        S_STIM: begin
          // a timeout can only fire at 9999, so r_bcd is the latched value in both exits
          if (w_resp_rise || (w_tick && (r_bcd == BCD_MAX))) begin
            r_result       <= r_bcd;
            r_result_valid <= 1'b1;
            r_trial        <= r_trial + 3'd1;
            if (r_bcd < r_best) r_best <= r_bcd;
            r_state <= S_RESULT;
            r_flags <= flags_of(S_RESULT);
          end else if (w_tick) begin
            r_bcd <= w_bcd_inc;
          end
        end
        S_RESULT: begin
          if (!resp_btn) begin
            if (r_trial == 3'(NUM_TRIALS)) begin
              r_state <= S_DONE;
              r_flags <= flags_of(S_DONE);
            end else begin
              r_prep_ms  <= w_prep_load;
              r_tick_cnt <= '0;
              r_state    <= S_PREP;
              r_flags    <= flags_of(S_PREP);
            end
          end
        end
        S_FAULT: begin
          if (!resp_btn) begin
            r_prep_ms  <= w_prep_load;
            r_tick_cnt <= '0;
            r_state    <= S_PREP;
            r_flags    <= flags_of(S_PREP);
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_flags <= flags_of(S_IDLE);
        end
      endcase
    end
  end

  assign state        = r_state;
  assign busy         = r_flags[2];
  assign stim_led     = r_flags[1];
  assign session_done = r_flags[0];
  assign trial_idx    = r_trial;
  assign result_bcd   = r_result;
  assign best_bcd     = r_best;
  assign result_valid = r_result_valid;
  assign false_start  = r_false_start;

endmodule

// File: tb/tb_reaction_session_ctrl.sv
// Scoreboard bench for reaction_session_ctrl: expected trial results are queued
// when the response (or timeout) is set up and checked on each result_valid pulse.
module tb_reaction_session_ctrl;

  localparam int unsigned TICK_DIV    = 2;  // short tick keeps the two 10000-tick STIM runs brief
  localparam int unsigned NUM_TRIALS  = 2;
  localparam int unsigned PREP_MIN_MS = 2;
  localparam int unsigned PICK_MAX    = 8;  // only start/release when lfsr[10:0] is this small
  localparam int unsigned PICK_LIMIT  = 20000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start_btn = 1'b0;
  logic        resp_btn = 1'b0;
  logic        stim_led, busy, result_valid, false_start, session_done;
  logic [2:0]  state, trial_idx;
  logic [15:0] result_bcd, best_bcd;

  reaction_session_ctrl #(
    .TICK_DIV    (TICK_DIV),
    .NUM_TRIALS  (NUM_TRIALS),
    .PREP_MIN_MS (PREP_MIN_MS)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start_btn    (start_btn),
    .resp_btn     (resp_btn),
    .stim_led     (stim_led),
    .busy         (busy),
    .state        (state),
    .trial_idx    (trial_idx),
    .result_bcd   (result_bcd),
    .best_bcd     (best_bcd),
    .result_valid (result_valid),
    .false_start  (false_start),
    .session_done (session_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] res;
    logic [15:0] best;
    logic [2:0]  idx;
  } exp_t;

  exp_t        sb_q[$];
  int unsigned n_checks = 0;
  int unsigned n_fail = 0;
  int unsigned rv_count = 0;
  int unsigned fs_count = 0;
  logic        rv_prev = 1'b0;
  int unsigned exp_prep = 0;
  int unsigned exp_best_ms = 9999;
  int unsigned exp_idx = 0;
  logic [15:0] m_lfsr;

  // Reference LFSR written out per bit from x^16+x^14+x^13+x^11+1
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_lfsr <= 16'hACE1;
    end else begin
      m_lfsr[15]  <= m_lfsr[0];
      m_lfsr[14]  <= m_lfsr[15];
      m_lfsr[13]  <= m_lfsr[14] ^ m_lfsr[0];
      m_lfsr[12]  <= m_lfsr[13] ^ m_lfsr[0];
      m_lfsr[11]  <= m_lfsr[12];
      m_lfsr[10]  <= m_lfsr[11] ^ m_lfsr[0];
      m_lfsr[9:0] <= m_lfsr[10:1];
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int unsigned v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (reset && result_valid) begin
      rv_count++;
      check_eq("rv_one_cycle", 32'(rv_prev), 32'd0);
      if (sb_q.size() == 0) begin
        check_eq("rv_unexpected", 32'(result_valid), 32'd0);
      end else begin
        e = sb_q.pop_front();
        check_eq("result_bcd", 32'(result_bcd), 32'(e.res));
        check_eq("best_bcd", 32'(best_bcd), 32'(e.best));
        check_eq("trial_idx", 32'(trial_idx), 32'(e.idx));
        check_eq("rv_state", 32'(state), 32'd3);
      end
    end
    if (reset && false_start) fs_count++;
    rv_prev = result_valid;
  end

  task automatic check_reset_values(input string tag);
    check_eq({tag, "_state"}, 32'(state), 32'd0);
    check_eq({tag, "_stim_led"}, 32'(stim_led), 32'd0);
    check_eq({tag, "_busy"}, 32'(busy), 32'd0);
    check_eq({tag, "_trial_idx"}, 32'(trial_idx), 32'd0);
    check_eq({tag, "_result_bcd"}, 32'(result_bcd), 32'h0000);
    check_eq({tag, "_best_bcd"}, 32'(best_bcd), 32'h9999);
    check_eq({tag, "_result_valid"}, 32'(result_valid), 32'd0);
    check_eq({tag, "_false_start"}, 32'(false_start), 32'd0);
    check_eq({tag, "_session_done"}, 32'(session_done), 32'd0);
  endtask

  task automatic wait_state(input logic [2:0] s, input int unsigned limit, input string tag,
                            output int unsigned n);
    n = 0;
    while (state !== s && n < limit) begin
      @(negedge clk);
      n++;
    end
    check_eq(tag, 32'(state), 32'(s));
  endtask

  // Waits for a small lfsr[10:0] so the next prep delay stays short
  task automatic pick_moment(input string tag);
    int unsigned n;
    n = 0;
    while (m_lfsr[10:0] >= 11'(PICK_MAX) && n < PICK_LIMIT) begin
      @(negedge clk);
      n++;
    end
    if (n >= PICK_LIMIT) check_eq({tag, "_pick_timeout"}, n, 32'd0);
    exp_prep = PREP_MIN_MS + 32'(m_lfsr[10:0]);
  endtask

  task automatic press_start(input string tag);
    start_btn = 1'b0;
    @(negedge clk);
    pick_moment(tag);
    start_btn   = 1'b1;
    exp_idx     = 0;
    exp_best_ms = 9999;
  endtask

  task automatic release_resp(input string tag);
    pick_moment(tag);
    resp_btn = 1'b0;
  endtask

  task automatic measure_prep(input string tag, input bit new_session);
    int unsigned n;
    wait_state(3'd1, 4, {tag, "_enter_prep"}, n);
    check_eq({tag, "_prep_busy"}, 32'(busy), 32'd1);
    if (new_session) begin
      check_eq({tag, "_new_idx"}, 32'(trial_idx), 32'd0);
      check_eq({tag, "_new_best"}, 32'(best_bcd), 32'h9999);
    end
    n = 0;
    while (state == 3'd1 && n < 50000) begin
      @(negedge clk);
      n++;
    end
    check_eq({tag, "_prep_cycles"}, n, exp_prep * TICK_DIV);
    check_eq({tag, "_stim_state"}, 32'(state), 32'd2);
    check_eq({tag, "_stim_led"}, 32'(stim_led), 32'd1);
  endtask

  task automatic expect_result(input int unsigned ms);
    exp_t e;
    exp_idx++;
    if (ms < exp_best_ms) exp_best_ms = ms;
    e.res  = to_bcd(ms);
    e.best = to_bcd(exp_best_ms);
    e.idx  = 3'(exp_idx);
    sb_q.push_back(e);
  endtask

  // Called on the first STIM negedge; responds so that exactly 'ms' ticks have elapsed
  task automatic respond_at(input string tag, input int unsigned ms, input bit poke_start);
    int unsigned n;
    if (poke_start) begin
      start_btn = 1'b0;
      @(negedge clk);
      start_btn = 1'b1;
      @(negedge clk);
      repeat (ms * TICK_DIV - 2) @(negedge clk);
    end else begin
      repeat (ms * TICK_DIV) @(negedge clk);
    end
    check_eq({tag, "_still_stim"}, 32'(state), 32'd2);
    resp_btn = 1'b1;
    expect_result(ms);
    wait_state(3'd3, 4, {tag, "_result"}, n);
  endtask

  initial begin
    int unsigned n;
    int unsigned fs_before;
    int unsigned rv_before;

    repeat (3) @(negedge clk);
    check_reset_values("por");
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Session A: normal trial, false start, timeout
    press_start("a1");
    measure_prep("a1", 1'b1);
    respond_at("a1", 37, 1'b0);
    repeat (2) @(negedge clk);
    check_eq("a1_idx_after", 32'(trial_idx), 32'd1);
    release_resp("a1");

    wait_state(3'd1, 4, "a2_prep", n);
    @(negedge clk);
    fs_before = fs_count;
    resp_btn  = 1'b1;
    @(negedge clk);
    check_eq("fs_state", 32'(state), 32'd4);
    check_eq("fs_pulse", 32'(false_start), 32'd1);
    repeat (3) @(negedge clk);
    check_eq("fs_count", fs_count - fs_before, 32'd1);
    check_eq("fs_pulse_end", 32'(false_start), 32'd0);
    check_eq("fs_hold_state", 32'(state), 32'd4);
    check_eq("fs_idx", 32'(trial_idx), 32'd1);
    release_resp("a2");
    measure_prep("a2", 1'b0);
    expect_result(9999);
    wait_state(3'd3, 10000 * TICK_DIV + 8, "to_result", n);
    check_eq("to_cycles", n, 10000 * TICK_DIV);
    wait_state(3'd5, 4, "a_done", n);
    check_eq("a_done_flag", 32'(session_done), 32'd1);
    check_eq("a_done_busy", 32'(busy), 32'd0);
    check_eq("a_done_best", 32'(best_bcd), 32'h0037);
    check_eq("a_done_result", 32'(result_bcd), 32'h9999);

    // Session B: best tracking, ignored start edge, session end on release
    press_start("b1");
    measure_prep("b1", 1'b1);
    respond_at("b1", 120, 1'b1);
    release_resp("b1");
    measure_prep("b2", 1'b0);
    respond_at("b2", 45, 1'b0);
    repeat (5) @(negedge clk);
    check_eq("b_hold_state", 32'(state), 32'd3);
    check_eq("b_hold_done", 32'(session_done), 32'd0);
    resp_btn = 1'b0;
    wait_state(3'd5, 4, "b_done", n);
    check_eq("b_done_flag", 32'(session_done), 32'd1);
    check_eq("b_done_idx", 32'(trial_idx), 32'd2);
    check_eq("b_done_best", 32'(best_bcd), 32'h0045);

    // Session C: response coinciding with the 9999 tick
    press_start("c1");
    measure_prep("c1", 1'b1);
    respond_at("c1", 5, 1'b0);
    release_resp("c1");
    measure_prep("c2", 1'b0);
    rv_before = rv_count;
    repeat (10000 * TICK_DIV - 1) @(negedge clk);
    resp_btn = 1'b1;
    expect_result(9999);
    wait_state(3'd3, 4, "co_result", n);
    repeat (2) @(negedge clk);
    resp_btn = 1'b0;
    wait_state(3'd5, 4, "c_done", n);
    check_eq("co_rv_count", rv_count - rv_before, 32'd1);
    check_eq("c_done_best", 32'(best_bcd), 32'h0005);

    // Session D: asynchronous reset in the middle of STIM
    press_start("d1");
    measure_prep("d1", 1'b1);
    respond_at("d1", 12, 1'b0);
    release_resp("d1");
    measure_prep("d2", 1'b0);
    repeat (6) @(negedge clk);
    check_eq("d_pre_rst_best", 32'(best_bcd), 32'h0012);
    #2;
    reset     = 1'b0;
    start_btn = 1'b0;
    #1;
    check_reset_values("mid_stim");
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("post_rst_state", 32'(state), 32'd0);

    check_eq("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
